// File: rtl/rv_control_fsm.sv
// rv_control_fsm: multi-cycle RV32I main controller.
// A Moore state machine walks each instruction through fetch, decode and its
// execution states, driving the ALU operation and every datapath select.
// The only Mealy term is the branch-taken PC load in BRANCH, which uses the
// ALU flags produced in that same cycle.
module rv_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       cout,
  input  logic       overflow,
  input  logic       sign,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic [3:0] aluc,
  output logic       illegal
);

  // Opcodes the controller understands; anything else traps.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operation encodings understood by the downstream ALU.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  // Source select encodings.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEMDAT = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [4:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BRANCH,
    JAL,
    JALR,
    JALRWB,
    LUI,
    AUIPC,
    TRAP
  } state_t;

  state_t state, next_state;

  // ALU operation for register and immediate arithmetic. Subtract exists
  // only for R-type (addi has no sub form); the arithmetic right shift is
  // selected by instr[30] in both formats.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_rtype);
    logic [3:0] result;
    case (f3)
      3'b000:  result = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  result = ALU_SLL;
      3'b010:  result = ALU_SLT;
      3'b011:  result = ALU_SLTU;
      3'b100:  result = ALU_XOR;
      3'b101:  result = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  result = ALU_OR;
      default: result = ALU_AND;
    endcase
    return result;
  endfunction

  // Branch condition from the flags of rs1 - rs2. Signed compares use
  // sign^overflow; unsigned compares use the carry (no borrow means rs1 >= rs2).
  function automatic logic branch_take(input logic [2:0] f3,
                                       input logic       z,
                                       input logic       c,
                                       input logic       v,
                                       input logic       n);
    logic result;
    case (f3)
      3'b000:  result = z;
      3'b001:  result = ~z;
      3'b100:  result = n ^ v;
      3'b101:  result = ~(n ^ v);
      3'b110:  result = ~c;
      3'b111:  result = c;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  // State register; reset drops straight back to IDLE, abandoning any
  // instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; every output defaults to zero.
  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    reg_write  = 1'b0;
    aluc       = ALU_ADD;
    illegal    = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end

      FETCH: begin
        adr_src    = 1'b0;
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        aluc       = ALU_ADD;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        next_state = DECODE;
      end

      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        aluc      = ALU_ADD;
        case (op)
          OP_LOAD,
          OP_STORE:  next_state = MEMADR;
          OP_RTYPE:  next_state = EXEC_R;
          OP_ITYPE:  next_state = EXEC_I;
          OP_BRANCH: next_state = BRANCH;
          OP_JAL:    next_state = JAL;
          OP_JALR:   next_state = JALR;
          OP_LUI:    next_state = LUI;
          OP_AUIPC:  next_state = AUIPC;
          default:   next_state = TRAP;
        endcase
      end

      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        aluc       = ALU_ADD;
        imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        next_state = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end

      MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        next_state = MEMWB;
      end

      MEMWB: begin
        result_src = RES_MEMDAT;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        next_state = FETCH;
      end

      EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluc       = alu_decode(funct3, funct7b5, 1'b1);
        next_state = ALUWB;
      end

      EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        aluc       = alu_decode(funct3, funct7b5, 1'b0);
        next_state = ALUWB;
      end

      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluc       = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = branch_take(funct3, zero, cout, overflow, sign);
        next_state = FETCH;
      end

      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        aluc       = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        next_state = ALUWB;
      end

      JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        aluc       = ALU_ADD;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        next_state = JALRWB;
      end

      JALRWB: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        aluc       = ALU_ADD;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        next_state = FETCH;
      end

      LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        aluc       = ALU_ADD;
        next_state = ALUWB;
      end

      AUIPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        aluc       = ALU_ADD;
        next_state = ALUWB;
      end

      TRAP: begin
        illegal    = 1'b1;
        next_state = TRAP;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_control_fsm.sv
// tb_rv_control_fsm: directed check of every controller output, cycle by
// cycle, against hand-written per-state vectors.
module tb_rv_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero, cout, overflow, sign;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic       reg_write;
  logic [3:0] aluc;
  logic       illegal;

  int checks;
  int failures;

  rv_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .cout       (cout),
    .overflow   (overflow),
    .sign       (sign),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .aluc       (aluc),
    .illegal    (illegal)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs packed into one word, in the same field order as mk().
  logic [18:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, aluc, illegal};

  function automatic logic [18:0] mk(input logic pcw, input logic adr,
                                     input logic memw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm,
                                     input logic rw, input logic [3:0] alu,
                                     input logic ill);
    return {pcw, adr, memw, irw, rs, sa, sb, imm, rw, alu, ill};
  endfunction

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic [18:0] v_zero, v_fetch, v_decode, v_decode_jal, v_memadr_lw, v_memadr_sw;
  logic [18:0] v_memread, v_memwb, v_memwrite, v_aluwb, v_jal, v_jalr, v_jalrwb;
  logic [18:0] v_lui, v_auipc, v_trap;

  function automatic logic [18:0] v_exec(input logic is_r, input logic [3:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_r ? 2'b00 : 2'b01, 3'b000,
              1'b0, alu, 1'b0);
  endfunction

  function automatic logic [18:0] v_branch(input logic take);
    return mk(take, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 4'b0001, 1'b0);
  endfunction

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  task automatic checkOutput(input string tag, input logic [18:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One four-cycle ALU instruction, entered with the DUT sitting in FETCH.
  task automatic runAlu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic is_r, input logic [3:0] alu);
    applyStimulus(o, f3, f7);
    tick(); checkOutput({tag, "_decode"}, v_decode);
    tick(); checkOutput({tag, "_exec"}, v_exec(is_r, alu));
    tick(); checkOutput({tag, "_aluwb"}, v_aluwb);
    tick(); checkOutput({tag, "_fetch"}, v_fetch);
  endtask

  // One three-cycle branch; flags are applied only while in BRANCH.
  task automatic runBranch(input string tag, input logic [2:0] f3, input logic z,
                           input logic c, input logic v, input logic n,
                           input logic take);
    applyStimulus(OP_BRANCH, f3, 1'b0);
    tick(); checkOutput({tag, "_decode"}, v_decode);
    tick();
    zero = z; cout = c; overflow = v; sign = n;
    #1 checkOutput({tag, "_branch"}, v_branch(take));
    tick(); checkOutput({tag, "_fetch"}, v_fetch);
    zero = 1'b0; cout = 1'b0; overflow = 1'b0; sign = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    v_zero       = '0;
    v_fetch      = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 4'b0000, 0);
    v_decode     = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 0, 4'b0000, 0);
    v_decode_jal = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b011, 0, 4'b0000, 0);
    v_memadr_lw  = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 4'b0000, 0);
    v_memadr_sw  = mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 0, 4'b0000, 0);
    v_memread    = mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'b0000, 0);
    v_memwb      = mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 4'b0000, 0);
    v_memwrite   = mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'b0000, 0);
    v_aluwb      = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 4'b0000, 0);
    v_jal        = mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 4'b0000, 0);
    v_jalr       = mk(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 0, 4'b0000, 0);
    v_jalrwb     = mk(0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 3'b000, 1, 4'b0000, 0);
    v_lui        = mk(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 0, 4'b0000, 0);
    v_auipc      = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 0, 4'b0000, 0);
    v_trap       = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 4'b0000, 1);

    // Reset held with flags asserted: everything stays zero.
    rst_n = 1'b0;
    applyStimulus(OP_BRANCH, 3'b000, 1'b0);
    zero = 1'b1; cout = 1'b1; overflow = 1'b1; sign = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_hold", v_zero);
    zero = 1'b0; cout = 1'b0; overflow = 1'b0; sign = 1'b0;

    // Release just after an edge: one IDLE cycle, then FETCH.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_release", v_zero);
    tick(); checkOutput("fetch_first", v_fetch);

    // Register and immediate arithmetic decode.
    runAlu("r_sub",  OP_RTYPE, 3'b000, 1'b1, 1'b1, 4'b0001);
    runAlu("r_add",  OP_RTYPE, 3'b000, 1'b0, 1'b1, 4'b0000);
    runAlu("i_addi", OP_ITYPE, 3'b000, 1'b1, 1'b0, 4'b0000);
    runAlu("i_srai", OP_ITYPE, 3'b101, 1'b1, 1'b0, 4'b0100);
    runAlu("r_srl",  OP_RTYPE, 3'b101, 1'b0, 1'b1, 4'b0110);
    runAlu("r_xor",  OP_RTYPE, 3'b100, 1'b0, 1'b1, 4'b1001);
    runAlu("r_sltu", OP_RTYPE, 3'b011, 1'b0, 1'b1, 4'b1000);
    runAlu("i_slli", OP_ITYPE, 3'b001, 1'b0, 1'b0, 4'b0111);

    // Load: five cycles, register write with memory data only in the last.
    applyStimulus(OP_LOAD, 3'b010, 1'b0);
    tick(); checkOutput("lw_decode", v_decode);
    tick(); checkOutput("lw_memadr", v_memadr_lw);
    tick(); checkOutput("lw_memread", v_memread);
    tick(); checkOutput("lw_memwb", v_memwb);
    tick(); checkOutput("lw_fetch", v_fetch);

    // Store: memory write only in cycle 4.
    applyStimulus(OP_STORE, 3'b010, 1'b0);
    tick(); checkOutput("sw_decode", v_decode);
    tick(); checkOutput("sw_memadr", v_memadr_sw);
    tick(); checkOutput("sw_memwrite", v_memwrite);
    tick(); checkOutput("sw_fetch", v_fetch);

    // Branch condition sweep, including the same-cycle flag dependence.
    runBranch("beq_taken",    3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    runBranch("beq_not",      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runBranch("bne_taken",    3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runBranch("blt_not",      3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    runBranch("blt_taken",    3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runBranch("bge_taken",    3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    runBranch("bltu_taken",   3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runBranch("bgeu_not",     3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runBranch("bgeu_taken",   3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    runBranch("f3_010_never", 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Jumps and upper-immediate instructions.
    applyStimulus(OP_JALR, 3'b000, 1'b0);
    tick(); checkOutput("jalr_decode", v_decode);
    tick(); checkOutput("jalr_exec", v_jalr);
    tick(); checkOutput("jalr_wb", v_jalrwb);
    tick(); checkOutput("jalr_fetch", v_fetch);

    applyStimulus(OP_JAL, 3'b000, 1'b0);
    tick(); checkOutput("jal_decode", v_decode_jal);
    tick(); checkOutput("jal_exec", v_jal);
    tick(); checkOutput("jal_wb", v_aluwb);
    tick(); checkOutput("jal_fetch", v_fetch);

    applyStimulus(OP_LUI, 3'b000, 1'b0);
    tick(); checkOutput("lui_decode", v_decode);
    tick(); checkOutput("lui_exec", v_lui);
    tick(); checkOutput("lui_wb", v_aluwb);
    tick(); checkOutput("lui_fetch", v_fetch);

    applyStimulus(OP_AUIPC, 3'b000, 1'b0);
    tick(); checkOutput("auipc_decode", v_decode);
    tick(); checkOutput("auipc_exec", v_auipc);
    tick(); checkOutput("auipc_wb", v_aluwb);
    tick(); checkOutput("auipc_fetch", v_fetch);

    // Unsupported opcode traps and holds regardless of inputs.
    applyStimulus(OP_BAD, 3'b000, 1'b0);
    tick(); checkOutput("trap_decode", v_decode);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("trap_hold_%0d", i), v_trap);
      applyStimulus(OP_RTYPE, 3'b000, 1'b0);
      zero = 1'b1;
    end
    zero = 1'b0;

    // Reset pulse clears the trap.
    rst_n = 1'b0;
    #1 checkOutput("trap_reset_async", v_zero);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("trap_reset_idle", v_zero);
    tick(); checkOutput("trap_reset_fetch", v_fetch);

    // Reset in MEMREAD abandons the load before its register write.
    applyStimulus(OP_LOAD, 3'b010, 1'b0);
    tick(); checkOutput("lwabort_decode", v_decode);
    tick(); checkOutput("lwabort_memadr", v_memadr_lw);
    tick(); checkOutput("lwabort_memread", v_memread);
    rst_n = 1'b0;
    #1 checkOutput("lwabort_reset_async", v_zero);
    tick(); checkOutput("lwabort_reset_held", v_zero);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("lwabort_idle", v_zero);
    tick(); checkOutput("lwabort_fetch", v_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
